// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment o/x patterns, result codes and helpers
//
// Purpose: constants shared by the o/x display encoder and seg7_ox_decoder.
// Segment buses are gfedcba with 0 meaning the segment is lit.
// Contents: SEG_* glyph patterns, RES_* 2-bit result codes, decoder FSM
// state type, and an 8-bit saturating increment.
package seg7_pkg;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_O    = 7'b0100011;
  localparam logic [6:0] SEG_X    = 7'b0001001;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_P    = 7'b0001100;

  localparam logic [1:0] RES_IDLE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_INV  = 2'b11;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } dec_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seg7_ox_classify.sv
// rtl/seg7_ox_classify.sv - combinational classifier of four seven-segment buses
//
// Purpose: map the registered display buses to a 2-bit result class.
// Ports:
//   hex5, hex4, hex2, hex0 : registered segment buses (gfedcba, 0 = lit)
//   cls                    : RES_IDLE, RES_P1, RES_P2, or RES_INV for anything else
module seg7_ox_classify
  import seg7_pkg::*;
(
  input  logic [6:0] hex5,
  input  logic [6:0] hex4,
  input  logic [6:0] hex2,
  input  logic [6:0] hex0,
  output logic [1:0] cls
);

  always_comb begin
    cls = RES_INV;
    if (hex5 == SEG_P && hex4 == SEG_1 && hex2 == SEG_O && hex0 == SEG_DASH) begin
      cls = RES_P1;
    end else if (hex5 == SEG_P && hex4 == SEG_2 && hex2 == SEG_DASH && hex0 == SEG_X) begin
      cls = RES_P2;
    end else if (hex5 == SEG_DASH && hex4 == SEG_DASH && hex2 == SEG_DASH && hex0 == SEG_DASH) begin
      cls = RES_IDLE;
    end
  end

endmodule

// File: rtl/seg7_ox_decoder.sv
// rtl/seg7_ox_decoder.sv - debounced o/x game result decoder for a seven-segment display
//
// Purpose: register the display buses, classify them, and accept a class as
// the result only after it has been seen on STABLE_CYCLES consecutive edges.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   Hex5, Hex4, Hex2, Hex0   : segment buses (gfedcba, 0 = lit)
//   result                   : accepted result (00 idle, 01 P1, 10 P2, 11 invalid)
//   result_valid             : one-cycle strobe when the accepted result changes
//   locked                   : high while the classification matches the accepted run
//   accept_count             : number of accepted changes, saturating at 255
module seg7_ox_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Hex5,
  input  logic [6:0] Hex4,
  input  logic [6:0] Hex2,
  input  logic [6:0] Hex0,
  output logic [1:0] result,
  output logic       result_valid,
  output logic       locked,
  output logic [7:0] accept_count
);

  // run_cnt counts repeats after the first sighting, so the run is complete
  // when it reaches STABLE_CYCLES-2 on an edge where the class still matches.
  localparam logic [7:0] RUN_TARGET = 8'(STABLE_CYCLES - 2);

  logic [6:0] hex5_q, hex4_q, hex2_q, hex0_q;
  logic [1:0] cls;
  logic [1:0] cand_q;
  logic [7:0] run_cnt;
  dec_state_t state;

  seg7_ox_classify u_classify (
    .hex5 (hex5_q),
    .hex4 (hex4_q),
    .hex2 (hex2_q),
    .hex0 (hex0_q),
    .cls  (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hex5_q       <= SEG_DASH;
      hex4_q       <= SEG_DASH;
      hex2_q       <= SEG_DASH;
      hex0_q       <= SEG_DASH;
      cand_q       <= RES_IDLE;
      run_cnt      <= 8'd0;
      state        <= SETTLE;
      result       <= RES_IDLE;
      result_valid <= 1'b0;
      accept_count <= 8'd0;
    end else begin
      hex5_q       <= Hex5;
      hex4_q       <= Hex4;
      hex2_q       <= Hex2;
      hex0_q       <= Hex0;
      cand_q       <= cls;
      run_cnt      <= (cls == cand_q) ? sat_inc(run_cnt) : 8'd0;
      result_valid <= 1'b0;

      case (state)
        SETTLE: begin
          if (cls == cand_q && run_cnt == RUN_TARGET) begin
            state <= LOCKED;
            // Re-settling onto the result already held is silent.
            if (cls != result) begin
              result       <= cls;
              result_valid <= 1'b1;
              accept_count <= sat_inc(accept_count);
            end
          end
        end
        LOCKED: begin
          if (cls != cand_q) begin
            state <= SETTLE;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_seg7_ox_decoder.sv
// tb/tb_seg7_ox_decoder.sv - self-checking bench for seg7_ox_decoder
module tb_seg7_ox_decoder;

  localparam int SC = 4;

  localparam logic [6:0] T_DASH = 7'b0111111;
  localparam logic [6:0] T_O    = 7'b0100011;
  localparam logic [6:0] T_X    = 7'b0001001;
  localparam logic [6:0] T_1    = 7'b1111001;
  localparam logic [6:0] T_2    = 7'b0100100;
  localparam logic [6:0] T_P    = 7'b0001100;

  localparam logic [1:0] E_IDLE = 2'b00;
  localparam logic [1:0] E_P1   = 2'b01;
  localparam logic [1:0] E_P2   = 2'b10;
  localparam logic [1:0] E_INV  = 2'b11;

  typedef struct {
    logic [1:0] res;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] hex5 = T_DASH, hex4 = T_DASH, hex2 = T_DASH, hex0 = T_DASH;
  logic [1:0] result;
  logic       result_valid;
  logic       locked;
  logic [7:0] accept_count;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  seg7_ox_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk          (clk),
    .reset        (reset),
    .Hex5         (hex5),
    .Hex4         (hex4),
    .Hex2         (hex2),
    .Hex0         (hex0),
    .result       (result),
    .result_valid (result_valid),
    .locked       (locked),
    .accept_count (accept_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match the oldest pending expectation, including the edge it lands on.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected cyc=%0d result=%0d count=%0d required no strobe",
                 cyc, result, accept_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || accept_count !== e.cnt || cyc !== e.cyc) begin
          bad++;
          $display("FAIL strobe got result=%0d count=%0d cyc=%0d required result=%0d count=%0d cyc=%0d",
                   result, accept_count, cyc, e.res, e.cnt, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d);
    hex5 = a;
    hex4 = b;
    hex2 = c;
    hex0 = d;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after the pattern is driven: first capture is the next edge,
  // acceptance SC edges after that.
  task automatic expect_strobe(input logic [1:0] res, input logic [7:0] cnt);
    exp_t e;
    e.res = res;
    e.cnt = cnt;
    e.cyc = cyc + 1 + SC;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s missing_strobe pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(T_P, T_1, T_O, T_DASH);
    step(3);
    total++;
    if (result !== E_IDLE) begin bad++; $display("FAIL reset_result got=%0d required=0", result); end
    total++;
    if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d required=0", result_valid); end
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0d required=0", locked); end
    total++;
    if (accept_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d required=0", accept_count); end
  endtask

  task automatic test_p1_accept;
    reset = 1'b0;
    expect_strobe(E_P1, 8'd1);
    step(1);
    total++;
    if (result_valid !== 1'b0) begin bad++; $display("FAIL p1_first_cycle_valid got=%0d required=0", result_valid); end
    step(SC + 4);
    total++;
    if (result !== E_P1) begin bad++; $display("FAIL p1_result got=%0d required=1", result); end
    total++;
    if (accept_count !== 8'd1) begin bad++; $display("FAIL p1_count got=%0d required=1", accept_count); end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL p1_locked got=%0d required=1", locked); end
    check_drained("p1");
  endtask

  task automatic test_glitch;
    logic saw_low;
    saw_low = 1'b0;
    drive(T_P, T_2, T_DASH, T_X);
    step(2);
    drive(T_P, T_1, T_O, T_DASH);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (locked === 1'b0) saw_low = 1'b1;
    end
    total++;
    if (saw_low !== 1'b1) begin bad++; $display("FAIL glitch_unlock got=%0d required=1", saw_low); end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL glitch_relock got=%0d required=1", locked); end
    total++;
    if (result !== E_P1) begin bad++; $display("FAIL glitch_result got=%0d required=1", result); end
    total++;
    if (accept_count !== 8'd1) begin bad++; $display("FAIL glitch_count got=%0d required=1", accept_count); end
    check_drained("glitch");
  endtask

  task automatic test_invalid_idle;
    drive(T_P, 7'b0000000, T_O, T_DASH);
    expect_strobe(E_INV, 8'd2);
    step(10);
    total++;
    if (result !== E_INV) begin bad++; $display("FAIL invalid_result got=%0d required=3", result); end
    drive(T_DASH, T_DASH, T_DASH, T_DASH);
    expect_strobe(E_IDLE, 8'd3);
    step(10);
    total++;
    if (result !== E_IDLE) begin bad++; $display("FAIL idle_result got=%0d required=0", result); end
    total++;
    if (accept_count !== 8'd3) begin bad++; $display("FAIL idle_count got=%0d required=3", accept_count); end
    check_drained("invalid_idle");
  endtask

  task automatic test_reset_mid_settle;
    drive(T_P, T_2, T_DASH, T_X);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_strobe(E_P2, 8'd1);
    step(1);
    total++;
    if (result_valid !== 1'b0) begin bad++; $display("FAIL midreset_early_valid got=%0d required=0", result_valid); end
    total++;
    if (result !== E_IDLE) begin bad++; $display("FAIL midreset_cleared_result got=%0d required=0", result); end
    step(SC + 3);
    total++;
    if (result !== E_P2) begin bad++; $display("FAIL midreset_result got=%0d required=2", result); end
    total++;
    if (accept_count !== 8'd1) begin bad++; $display("FAIL midreset_count got=%0d required=1", accept_count); end
    check_drained("reset_mid");
  endtask

  task automatic test_saturation;
    logic [7:0] cnt;
    logic [1:0] cur;
    cnt = 8'd1;
    cur = E_P2;
    for (int i = 0; i < 260; i++) begin
      if (cur == E_P2) begin
        cur = E_P1;
        drive(T_P, T_1, T_O, T_DASH);
      end else begin
        cur = E_P2;
        drive(T_P, T_2, T_DASH, T_X);
      end
      if (cnt != 8'd255) cnt = cnt + 8'd1;
      expect_strobe(cur, cnt);
      step(6);
    end
    total++;
    if (accept_count !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d required=255", accept_count); end
    total++;
    if (result !== cur) begin bad++; $display("FAIL sat_result got=%0d required=%0d", result, cur); end
    check_drained("saturation");
  endtask

  initial begin
    test_reset();
    test_p1_accept();
    test_glitch();
    test_invalid_idle();
    test_reset_mid_settle();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
